// File: rtl/formal_output_checker.sv
// Output comparator for fabric-vs-reference equivalence runs: discards a number of
// warm-up strobes, compares a fixed number of samples under a per-bit mask, and reports a verdict.
module formal_output_checker #(
    parameter int WIDTH        = 1,
    parameter int CNT_W        = 16,
    parameter int SKIP_SAMPLES = 1,
    parameter int RUN_SAMPLES  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sample_en,
    input  logic [WIDTH-1:0] fpga_out,
    input  logic [WIDTH-1:0] bench_out,
    input  logic [WIDTH-1:0] bench_valid,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             mismatch,
    output logic [WIDTH-1:0] mismatch_vec,
    output logic [CNT_W-1:0] nb_error,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [WIDTH-1:0] first_err_vec
);

    // The run index may need more bits than CNT_W (e.g. 20 samples with a 4-bit
    // counter); first_err_idx reports the low CNT_W bits of it.
    localparam int RUN_NEED = $clog2(RUN_SAMPLES + 1);
    localparam int IDX_W    = (CNT_W > RUN_NEED) ? CNT_W : RUN_NEED;
    localparam int SKIP_NEED = $clog2(SKIP_SAMPLES + 1);
    localparam int SKIP_W   = (SKIP_NEED > 1) ? SKIP_NEED : 1;
    localparam logic [IDX_W-1:0]  RUN_LAST  = IDX_W'(RUN_SAMPLES - 1);
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_SAMPLES > 0) ? SKIP_SAMPLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, SKIP, RUN, DONE} state_t;

    state_t             state_reg, state_next;
    logic [SKIP_W-1:0]  skip_cnt_reg;
    logic [IDX_W-1:0]   run_idx_reg;
    logic               first_seen_reg;
    logic               mismatch_reg;
    logic [WIDTH-1:0]   mismatch_vec_reg;
    logic [CNT_W-1:0]   nb_error_reg;
    logic [CNT_W-1:0]   first_err_idx_reg;
    logic [WIDTH-1:0]   first_err_vec_reg;

    logic               start_run;
    logic               skip_strobe;
    logic               run_strobe;
    logic [WIDTH-1:0]   diff;
    logic               any_diff;

    assign start_run   = ((state_reg == IDLE) || (state_reg == DONE)) && start;
    assign skip_strobe = (state_reg == SKIP) && sample_en;
    assign run_strobe  = (state_reg == RUN) && sample_en;
    assign diff        = (fpga_out ^ bench_out) & bench_valid;
    assign any_diff    = |diff;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    state_next = (SKIP_SAMPLES == 0) ? RUN : SKIP;
                end
            end
            SKIP: begin
                if (sample_en && (skip_cnt_reg == SKIP_LAST)) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (sample_en && (run_idx_reg == RUN_LAST)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        pass = 1'b0;
        case (state_reg)
            SKIP, RUN: busy = 1'b1;
            DONE: begin
                done = 1'b1;
                pass = (nb_error_reg == '0);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || start_run) begin
            skip_cnt_reg      <= '0;
            run_idx_reg       <= '0;
            first_seen_reg    <= 1'b0;
            mismatch_reg      <= 1'b0;
            mismatch_vec_reg  <= '0;
            nb_error_reg      <= '0;
            first_err_idx_reg <= '1;
            first_err_vec_reg <= '0;
        end else begin
            if (skip_strobe) begin
                skip_cnt_reg <= skip_cnt_reg + 1'b1;
            end
            if (run_strobe) begin
                run_idx_reg      <= run_idx_reg + 1'b1;
                mismatch_vec_reg <= diff;
                mismatch_reg     <= any_diff;
                if (any_diff && (nb_error_reg != '1)) begin
                    nb_error_reg <= nb_error_reg + 1'b1;
                end
                if (any_diff && !first_seen_reg) begin
                    first_seen_reg    <= 1'b1;
                    first_err_idx_reg <= CNT_W'(run_idx_reg);
                    first_err_vec_reg <= diff;
                end
            end
        end
    end

    assign mismatch      = mismatch_reg;
    assign mismatch_vec  = mismatch_vec_reg;
    assign nb_error      = nb_error_reg;
    assign first_err_idx = first_err_idx_reg;
    assign first_err_vec = first_err_vec_reg;

endmodule

// File: tb/tb_formal_output_checker.sv
// Bench for formal_output_checker: two instances (skip/no-skip, wide/narrow counter)
// driven by shared stimulus and checked every cycle against a run-level model.
module tb_formal_output_checker;

    logic       clk = 1'b0;
    logic       rst, start, sample_en;
    logic [3:0] fpga, bench, valid;

    logic        a_busy, a_done, a_pass, a_mm;
    logic [3:0]  a_mm_vec, a_first_vec;
    logic [15:0] a_nb, a_first_idx;
    logic        b_busy, b_done, b_pass, b_mm;
    logic [1:0]  b_mm_vec, b_first_vec;
    logic [3:0]  b_nb, b_first_idx;

    int n_err = 0;
    int n_checks = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    formal_output_checker #(.WIDTH(4), .CNT_W(16), .SKIP_SAMPLES(1), .RUN_SAMPLES(10)) dut_a (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
        .fpga_out(fpga), .bench_out(bench), .bench_valid(valid),
        .busy(a_busy), .done(a_done), .pass(a_pass), .mismatch(a_mm),
        .mismatch_vec(a_mm_vec), .nb_error(a_nb), .first_err_idx(a_first_idx),
        .first_err_vec(a_first_vec)
    );

    formal_output_checker #(.WIDTH(2), .CNT_W(4), .SKIP_SAMPLES(0), .RUN_SAMPLES(20)) dut_b (
        .clk(clk), .rst(rst), .start(start), .sample_en(sample_en),
        .fpga_out(fpga[1:0]), .bench_out(bench[1:0]), .bench_valid(valid[1:0]),
        .busy(b_busy), .done(b_done), .pass(b_pass), .mismatch(b_mm),
        .mismatch_vec(b_mm_vec), .nb_error(b_nb), .first_err_idx(b_first_idx),
        .first_err_vec(b_first_vec)
    );

    // Run-level model: count strobes since start, compare those past the skip window.
    typedef struct {
        bit         active;
        bit         fin;
        int         strobes;
        int         errs;
        int         first_idx;
        logic [3:0] first_vec;
        logic [3:0] last_vec;
    } mdl_t;

    mdl_t ma, mb;

    function automatic mdl_t mdl_clear(input mdl_t m);
        mdl_t r = m;
        r.strobes = 0; r.errs = 0; r.first_idx = -1;
        r.first_vec = 4'h0; r.last_vec = 4'h0;
        return r;
    endfunction

    function automatic mdl_t step(input mdl_t m, input bit r, input bit st, input bit se,
                                  input logic [3:0] d, input int skip, input int run);
        mdl_t n = m;
        int idx;
        if (r) begin
            n = mdl_clear(n);
            n.active = 1'b0; n.fin = 1'b0;
        end else if (!m.active && st) begin
            n = mdl_clear(n);
            n.active = 1'b1; n.fin = 1'b0;
        end else if (m.active && se) begin
            if (m.strobes >= skip) begin
                idx = m.strobes - skip;
                n.last_vec = d;
                if (d != 4'h0) begin
                    n.errs = m.errs + 1;
                    if (m.first_idx < 0) begin
                        n.first_idx = idx;
                        n.first_vec = d;
                    end
                end
                if (idx == run - 1) begin
                    n.active = 1'b0; n.fin = 1'b1;
                end
            end
            n.strobes = m.strobes + 1;
        end
        return n;
    endfunction

    always @(posedge clk) begin
        logic [3:0] d;
        d = (fpga ^ bench) & valid;
        ma = step(ma, rst, start, sample_en, d, 1, 10);
        mb = step(mb, rst, start, sample_en, d & 4'b0011, 0, 20);
        if (rst) chk_en = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_busy", 32'(a_busy), 32'(ma.active));
            chk("a_done", 32'(a_done), 32'(ma.fin));
            chk("a_pass", 32'(a_pass), 32'(ma.fin && ma.errs == 0));
            chk("a_mismatch", 32'(a_mm), 32'(ma.last_vec != 4'h0));
            chk("a_mismatch_vec", 32'(a_mm_vec), 32'(ma.last_vec));
            chk("a_nb_error", 32'(a_nb), (ma.errs > 65535) ? 32'd65535 : 32'(ma.errs));
            chk("a_first_err_idx", 32'(a_first_idx), (ma.first_idx < 0) ? 32'hFFFF : 32'(ma.first_idx & 16'hFFFF));
            chk("a_first_err_vec", 32'(a_first_vec), 32'(ma.first_vec));
            chk("b_busy", 32'(b_busy), 32'(mb.active));
            chk("b_done", 32'(b_done), 32'(mb.fin));
            chk("b_pass", 32'(b_pass), 32'(mb.fin && mb.errs == 0));
            chk("b_mismatch", 32'(b_mm), 32'(mb.last_vec != 4'h0));
            chk("b_mismatch_vec", 32'(b_mm_vec), 32'(mb.last_vec[1:0]));
            chk("b_nb_error", 32'(b_nb), (mb.errs > 15) ? 32'd15 : 32'(mb.errs));
            chk("b_first_err_idx", 32'(b_first_idx), (mb.first_idx < 0) ? 32'hF : 32'(mb.first_idx & 15));
            chk("b_first_err_vec", 32'(b_first_vec), 32'(mb.first_vec[1:0]));
        end
    end

    task automatic drive(input bit r, input bit st, input bit se,
                         input logic [3:0] f, input logic [3:0] b, input logic [3:0] v);
        rst = r; start = st; sample_en = se; fpga = f; bench = b; valid = v;
        @(posedge clk);
        #1;
    endtask

    task automatic clean(input int n);
        logic [3:0] x;
        for (int i = 0; i < n; i++) begin
            x = 4'($urandom);
            drive(0, 0, 1, x, x, 4'($urandom));
        end
    endtask

    task automatic fresh();
        drive(1, 0, 0, 4'h0, 4'h0, 4'h0);
    endtask

    initial begin
        bit r, st, se;
        logic [3:0] f, flip;

        // Reset values
        fresh();
        fresh();
        chk("lit_rst_busy", 32'(a_busy), 32'd0);
        chk("lit_rst_nb", 32'(a_nb), 32'd0);
        chk("lit_rst_first_idx_a", 32'(a_first_idx), 32'hFFFF);
        chk("lit_rst_first_idx_b", 32'(b_first_idx), 32'hF);

        // Identical outputs; the start cycle carries a mismatching strobe that must be ignored
        drive(0, 1, 1, 4'hF, 4'h0, 4'hF);
        clean(11);
        chk("lit_ident_done", 32'(a_done), 32'd1);
        chk("lit_ident_pass", 32'(a_pass), 32'd1);
        chk("lit_ident_nb", 32'(a_nb), 32'd0);
        chk("lit_ident_first_idx", 32'(a_first_idx), 32'hFFFF);

        // Single fault on RUN sample 3 (overall strobe 4)
        fresh();
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 11; i++) begin
            if (i == 4) drive(0, 0, 1, 4'h1, 4'h0, 4'hF);
            else        drive(0, 0, 1, 4'h6, 4'h6, 4'hF);
            if (i == 4) chk("lit_fault_mm_on", 32'(a_mm), 32'd1);
            if (i == 5) chk("lit_fault_mm_off", 32'(a_mm), 32'd0);
        end
        chk("lit_fault_nb", 32'(a_nb), 32'd1);
        chk("lit_fault_first_idx", 32'(a_first_idx), 32'd3);
        chk("lit_fault_first_vec", 32'(a_first_vec), 32'h1);
        chk("lit_fault_pass", 32'(a_pass), 32'd0);

        // Mismatch only on the skipped strobe
        fresh();
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        drive(0, 0, 1, 4'hF, 4'h0, 4'hF);
        clean(10);
        chk("lit_skip_nb", 32'(a_nb), 32'd0);
        chk("lit_skip_pass", 32'(a_pass), 32'd1);

        // Masked bits never count
        fresh();
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) begin
            f = 4'($urandom);
            drive(0, 0, 1, f, f ^ 4'b1010, 4'b0101);
        end
        chk("lit_mask_nb_a", 32'(a_nb), 32'd0);
        chk("lit_mask_nb_b", 32'(b_nb), 32'd0);
        chk("lit_mask_done_b", 32'(b_done), 32'd1);
        chk("lit_mask_pass_b", 32'(b_pass), 32'd1);

        // Saturation of the 4-bit error counter
        fresh();
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        for (int i = 0; i < 20; i++) drive(0, 0, 1, 4'hF, 4'h0, 4'hF);
        chk("lit_sat_nb_b", 32'(b_nb), 32'd15);
        chk("lit_sat_done_b", 32'(b_done), 32'd1);
        chk("lit_sat_nb_a", 32'(a_nb), 32'd10);

        // Reset at RUN sample 5 after two errors, then a clean run
        fresh();
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        clean(1);
        drive(0, 0, 1, 4'h2, 4'h0, 4'hF);
        drive(0, 0, 1, 4'h2, 4'h0, 4'hF);
        clean(3);
        chk("lit_mid_nb", 32'(a_nb), 32'd2);
        drive(1, 1, 1, 4'hF, 4'h0, 4'hF);
        chk("lit_mid_busy", 32'(a_busy), 32'd0);
        chk("lit_mid_nb0", 32'(a_nb), 32'd0);
        chk("lit_mid_done", 32'(a_done), 32'd0);
        drive(0, 1, 0, 4'h0, 4'h0, 4'h0);
        clean(11);
        chk("lit_mid_pass", 32'(a_pass), 32'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            r  = ($urandom_range(0, 199) == 0);
            st = ($urandom_range(0, 14) == 0);
            se = ($urandom_range(0, 9) < 6);
            f  = 4'($urandom);
            flip = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            drive(r, st, se, f, f ^ flip, 4'($urandom));
        end

        drive(0, 0, 0, 4'h0, 4'h0, 4'h0);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/formal_output_checker.md
# formal_output_checker

Synthesizable, cycle-driven output comparator for design-vs-fabric equivalence runs. It sits directly downstream of the FPGA fabric under test and the reference benchmark. On each sample strobe it compares their output vectors, ignoring bits whose reference value is marked invalid, and counts mismatches. It reports a pass/fail verdict after a programmed number of samples, so the random-stimulus equivalence check can run on silicon or emulation instead of only in a simulator.

## Interface
- `WIDTH`, default 1: number of compared output bits.
- `CNT_W`, default 16: width of the error counter and the sample index counter.
- `SKIP_SAMPLES`, default 1: number of initial strobes discarded for initialization; 0 is legal.
- `RUN_SAMPLES`, default 10: number of compared strobes per run; must be ≥1.

Ports:
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: one-cycle pulse that begins a run; honoured in IDLE and DONE only.
- `sample_en` in 1: strobe marking the cycle in which `fpga_out`, `bench_out` and `bench_valid` are stable.
- `fpga_out` in WIDTH: fabric outputs.
- `bench_out` in WIDTH: reference benchmark outputs.
- `bench_valid` in WIDTH: per-bit compare enable; 0 masks the bit, as for an unknown reference value.
- `busy` out 1: high in SKIP and RUN.
- `done` out 1: high in DONE.
- `pass` out 1: valid while `done`; 1 when `nb_error` is 0.
- `mismatch` out 1: registered per-sample mismatch flag.
- `mismatch_vec` out WIDTH: registered per-bit mismatch of the last compared sample.
- `nb_error` out CNT_W: saturating count of mismatching samples.
- `first_err_idx` out CNT_W: RUN sample index (0-based) of the first mismatch; all-ones if none.
- `first_err_vec` out WIDTH: `mismatch_vec` captured at the first mismatch.

## Operation
- The FSM has four states: IDLE, SKIP, RUN, DONE. Reset state is IDLE.
- Transitions:
  - IDLE/DONE + `start`: go to SKIP, or to RUN if `SKIP_SAMPLES`=0. The same edge clears `nb_error`, the sample counters, `mismatch`, `mismatch_vec` and `first_err_vec`. It also sets `first_err_idx` to all-ones.
  - SKIP: each `sample_en` increments the skip counter. On the strobe that reaches `SKIP_SAMPLES`, the FSM goes to RUN. Skipped samples are never compared.
  - RUN: each `sample_en` forms `diff = (fpga_out ^ bench_out) & bench_valid`.
    - `mismatch_vec` ← `diff`; `mismatch` ← |`diff`.
    - If |`diff` and `nb_error` is below all-ones, `nb_error` increments; otherwise it holds (saturation).
    - If |`diff` and this is the first mismatch of the run, the sample index is latched into `first_err_idx` and `diff` into `first_err_vec`.
    - The sample index increments. On the strobe where index = `RUN_SAMPLES`-1, the FSM goes to DONE.
  - DONE holds all results until `start` or `rst`.
- `start` is ignored while busy.
- `mismatch` and `mismatch_vec` hold their value between strobes. They are not cleared by a non-strobe cycle.
- A sample whose bits are all masked by `bench_valid`=0 counts as a match.

## Timing
- Reset values (the cycle after `rst` is sampled high):
  - `busy`=0, `done`=0, `pass`=0, `mismatch`=0.
  - `mismatch_vec`=0, `nb_error`=0, `first_err_vec`=0.
  - `first_err_idx`=all-ones.
- Compare latency is 1 cycle: the results of a strobe at edge N appear after edge N.
- `done` rises on the edge that registers the final RUN sample. `nb_error` already includes that sample and `pass` is valid in the same cycle.
- `start` and `sample_en` in the same cycle from IDLE: the strobe is not consumed. Counting begins on the next strobe.
- Back-to-back strobes (every cycle) are supported; there is no required gap.
- `rst` mid-run (SKIP or RUN) aborts immediately to IDLE with reset values. No partial verdict is reported.
- `rst` takes precedence over `start` and `sample_en`.

## Test plan
- Identical outputs: `WIDTH`=1, `SKIP_SAMPLES`=1, `RUN_SAMPLES`=10, `fpga_out`=`bench_out` on 11 strobes.
  - Required: `done`=1, `pass`=1, `nb_error`=0, `first_err_idx`=16'hFFFF.
- Single fault: mismatch injected only on RUN sample 3.
  - Required: `nb_error`=1, `first_err_idx`=3, `first_err_vec`=1, `pass`=0.
  - `mismatch`=1 for exactly the window between strobe 3 and strobe 4.
- Skip-window masking: mismatch present only on the skipped strobe.
  - Required: `nb_error`=0, `pass`=1.
- Invalid-bit masking: `WIDTH`=2, `bench_valid`=2'b01, bit 1 always mismatching, bit 0 always matching.
  - Required: `nb_error`=0, `mismatch`=0 throughout.
- Saturation: `CNT_W`=4, `RUN_SAMPLES`=20, every sample mismatching.
  - Required: `nb_error`=15 at `done`, with no wrap to 0.
- Reset mid-run: `rst` asserted at RUN sample 5 after 2 errors.
  - Required next cycle: IDLE, `nb_error`=0, `busy`=0.
  - A following `start` and a clean run yields `pass`=1.
